// File: rtl/pipe_decoder_tree_pkg.sv
// Shared mode encodings and sizing helpers for the pipelined decoder tree.
package decoder_pkg;

    localparam logic MODE_ONEHOT = 1'b0;
    localparam logic MODE_ACC    = 1'b1;

    function automatic int levels(input int in_w, input int sub_w);
        return in_w / sub_w;
    endfunction

    // Width of the partial one-hot vector produced by tree level 'stage'.
    function automatic int part_w(input int stage, input int sub_w);
        return 1 << ((stage + 1) * sub_w);
    endfunction

endpackage

// File: rtl/pipe_decoder_tree_if.sv
// Sample-in / vector-out bundle of the pipelined decoder tree.
interface pipe_decoder_tree_if #(
    parameter int IN_W = 6
);
    localparam int OUT_W = 1 << IN_W;

    logic             decoder_en;
    logic [IN_W-1:0]  decoder_in;
    logic             decoder_mode;
    logic             decoder_clr;
    logic [OUT_W-1:0] decoder_out;
    logic             decoder_valid;
    logic             decoder_dup;

    modport master (
        output decoder_en, decoder_in, decoder_mode, decoder_clr,
        input  decoder_out, decoder_valid, decoder_dup
    );

    modport slave (
        input  decoder_en, decoder_in, decoder_mode, decoder_clr,
        output decoder_out, decoder_valid, decoder_dup
    );
endinterface

// File: rtl/pipe_decoder_tree_stage.sv
// Enable-gated SUB_W to 2^SUB_W one-hot leaf used at every tree node.
module decoder_stage #(
    parameter int SUB_W = 3
) (
    input  logic                   en,
    input  logic [SUB_W-1:0]       code,
    output logic [(1<<SUB_W)-1:0]  onehot
);
    always_comb begin
        onehot = '0;
        if (en) onehot[code] = 1'b1;
    end
endmodule

// File: rtl/pipe_decoder_tree.sv
// Pipelined binary-to-one-hot decoder tree with a held accumulate mask at the output.
module pipe_decoder_tree
    import decoder_pkg::*;
#(
    parameter int IN_W  = 6,
    parameter int SUB_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    pipe_decoder_tree_if.slave bus
);
    localparam int LEVELS = levels(IN_W, SUB_W);
    localparam int OUT_W  = 1 << IN_W;
    localparam int NS     = 1 << SUB_W;

    if (SUB_W < 1 || IN_W < SUB_W || (IN_W % SUB_W) != 0) begin : g_param_check
        $error("pipe_decoder_tree: IN_W must be a non-zero multiple of SUB_W");
    end

    // Level k decodes code field k under every set bit of the previous level.
    for (genvar k = 0; k < LEVELS; k++) begin : lvl
        localparam int PW_IN  = (k == 0) ? 1 : part_w(k - 1, SUB_W);
        localparam int PW_OUT = part_w(k, SUB_W);
        localparam int RW_IN  = IN_W - k * SUB_W;

        logic [PW_IN-1:0]  par_in;
        logic [RW_IN-1:0]  rem_in;
        logic              vld_in;
        logic              mode_in;
        logic [PW_OUT-1:0] dec;

        if (k == 0) begin : g_src
            assign par_in  = bus.decoder_en;
            assign rem_in  = bus.decoder_in;
            assign vld_in  = bus.decoder_en;
            assign mode_in = bus.decoder_mode;
        end else begin : g_src
            assign par_in  = lvl[k-1].g_reg.vec_p;
            assign rem_in  = lvl[k-1].g_reg.rem_p;
            assign vld_in  = lvl[k-1].g_reg.vld_p;
            assign mode_in = lvl[k-1].g_reg.mode_p;
        end

        for (genvar j = 0; j < PW_IN; j++) begin : sub
            decoder_stage #(.SUB_W(SUB_W)) u_stage (
                .en     (par_in[j]),
                .code   (rem_in[RW_IN-1 -: SUB_W]),
                .onehot (dec[j*NS +: NS])
            );
        end

        // ---- stage k register boundary (last level feeds the output register) ----
        if (k < LEVELS - 1) begin : g_reg
            logic [PW_OUT-1:0]      vec_p;
            logic [RW_IN-SUB_W-1:0] rem_p;
            logic                   vld_p;
            logic                   mode_p;

            always_ff @(posedge clk) begin
                if (rst) vld_p <= 1'b0;
                else     vld_p <= vld_in;
                vec_p  <= dec;
                rem_p  <= rem_in[RW_IN-SUB_W-1:0];
                mode_p <= mode_in;
            end
        end
    end

    logic [OUT_W-1:0] d;
    logic             v;
    logic             m;
    logic [OUT_W-1:0] out_p;
    logic [OUT_W-1:0] out_nxt;
    logic             valid_p;
    logic             dup_p;
    logic             dup_nxt;
    logic             last_mode;

    assign d = lvl[LEVELS-1].dec;
    assign v = lvl[LEVELS-1].vld_in;
    assign m = lvl[LEVELS-1].mode_in;

    // Clear wins over the held mask but never over a one-hot overwrite.
    always_comb begin
        out_nxt = out_p;
        if (v) begin
            if (m == MODE_ONEHOT || bus.decoder_clr) out_nxt = d;
            else                                     out_nxt = out_p | d;
        end else if (bus.decoder_clr || last_mode == MODE_ONEHOT) begin
            out_nxt = '0;
        end
        dup_nxt = v && (m == MODE_ACC) && !bus.decoder_clr && (|(out_p & d));
    end

    // ---- output stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_p     <= '0;
            valid_p   <= 1'b0;
            dup_p     <= 1'b0;
            last_mode <= MODE_ONEHOT;
        end else begin
            out_p   <= out_nxt;
            valid_p <= v;
            dup_p   <= dup_nxt;
            if (v) last_mode <= m;
        end
    end

    assign bus.decoder_out   = out_p;
    assign bus.decoder_valid = valid_p;
    assign bus.decoder_dup   = dup_p;
endmodule

// File: tb/tb_pipe_decoder_tree.sv
// Scoreboard bench: two decoder trees (6/3 and 8/2) driven with directed vectors.
module tb_pipe_decoder_tree;
    import decoder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pipe_decoder_tree_if #(.IN_W(6)) bus_a ();
    pipe_decoder_tree_if #(.IN_W(8)) bus_b ();

    pipe_decoder_tree #(.IN_W(6), .SUB_W(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    pipe_decoder_tree #(.IN_W(8), .SUB_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    typedef struct {
        int           inst;
        int           due;
        logic         v;
        logic [255:0] out;
        logic         dup;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic expect_at(input int inst, input int due, input logic v,
                             input logic [255:0] o, input logic dup, input string nm);
        exp_t x;
        x.inst = inst; x.due = due; x.v = v; x.out = o; x.dup = dup; x.name = nm;
        sb.push_back(x);
    endtask

    // Drive one cycle of stimulus; the instance not selected sits idle.
    task automatic step(input logic r, input int inst, input logic e, input int code,
                        input logic m, input logic clr, output int c);
        @(posedge clk);
        #1;
        rst                = r;
        bus_a.decoder_en   = (inst == 0) ? e : 1'b0;
        bus_a.decoder_in   = (inst == 0) ? 6'(code) : 6'd0;
        bus_a.decoder_mode = (inst == 0) ? m : 1'b0;
        bus_a.decoder_clr  = (inst == 0) ? clr : 1'b0;
        bus_b.decoder_en   = (inst == 1) ? e : 1'b0;
        bus_b.decoder_in   = (inst == 1) ? 8'(code) : 8'd0;
        bus_b.decoder_mode = (inst == 1) ? m : 1'b0;
        bus_b.decoder_clr  = (inst == 1) ? clr : 1'b0;
        c = cyc;
    endtask

    // Reset cycle: everything visible over the next LEVELS cycles must be zero.
    task automatic rst_step(input logic e, input int code);
        int c;
        step(1'b1, 0, e, code, MODE_ONEHOT, 1'b0, c);
        for (int i = 1; i <= 2; i++) expect_at(0, c + i, 1'b0, '0, 1'b0, "reset_a");
        for (int i = 1; i <= 4; i++) expect_at(1, c + i, 1'b0, '0, 1'b0, "reset_b");
    endtask

    // Instance A: expectation is what the output shows 2 cycles after this step.
    task automatic a_sample(input logic e, input int code, input logic m, input logic clr,
                            input logic ev, input logic [63:0] eo, input logic ed,
                            input string nm);
        int c;
        step(1'b0, 0, e, code, m, clr, c);
        expect_at(0, c + 2, ev, {192'd0, eo}, ed, nm);
    endtask

    task automatic b_sample(input logic e, input int code, input string nm);
        int c;
        logic [255:0] one;
        logic [255:0] eo;
        one = 256'd1;
        eo  = e ? (one << code) : '0;
        step(1'b0, 1, e, code, MODE_ONEHOT, 1'b0, c);
        expect_at(1, c + 4, e, eo, 1'b0, nm);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                logic [255:0] ao;
                logic         av;
                logic         ad;
                if (sb[i].inst == 0) begin
                    ao = {192'd0, bus_a.decoder_out};
                    av = bus_a.decoder_valid;
                    ad = bus_a.decoder_dup;
                end else begin
                    ao = bus_b.decoder_out;
                    av = bus_b.decoder_valid;
                    ad = bus_b.decoder_dup;
                end
                total++;
                if (av !== sb[i].v || ad !== sb[i].dup || ao !== sb[i].out) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got v=%0b dup=%0b out=%h want v=%0b dup=%0b out=%h",
                             sb[i].name, cyc, av, ad, ao, sb[i].v, sb[i].dup, sb[i].out);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus_a.decoder_en = 1'b0; bus_a.decoder_in = '0; bus_a.decoder_mode = 1'b0; bus_a.decoder_clr = 1'b0;
        bus_b.decoder_en = 1'b0; bus_b.decoder_in = '0; bus_b.decoder_mode = 1'b0; bus_b.decoder_clr = 1'b0;

        rst_step(1'b0, 0);
        rst_step(1'b0, 0);

        for (int i = 0; i < 64; i++)
            a_sample(1'b1, i, MODE_ONEHOT, 1'b0, 1'b1, 64'd1 << i, 1'b0, "sweep");

        a_sample(1'b1, 5,  MODE_ONEHOT, 1'b0, 1'b1, 64'h20, 1'b0, "gap_code5");
        a_sample(1'b0, 0,  MODE_ONEHOT, 1'b0, 1'b0, 64'h0,  1'b0, "gap_bubble");
        a_sample(1'b1, 62, MODE_ONEHOT, 1'b0, 1'b1, 64'h4000_0000_0000_0000, 1'b0, "gap_code62");
        a_sample(1'b0, 0,  MODE_ONEHOT, 1'b0, 1'b0, 64'h0,  1'b0, "acc_pre_bubble");

        a_sample(1'b1, 1,  MODE_ACC, 1'b0, 1'b1, 64'h2,   1'b0, "acc_1");
        a_sample(1'b1, 8,  MODE_ACC, 1'b0, 1'b1, 64'h102, 1'b0, "acc_8");
        a_sample(1'b1, 63, MODE_ACC, 1'b0, 1'b1, 64'h8000_0000_0000_0102, 1'b0, "acc_63");
        a_sample(1'b1, 8,  MODE_ACC, 1'b0, 1'b1, 64'h8000_0000_0000_0102, 1'b1, "acc_dup8");
        a_sample(1'b0, 0,  MODE_ACC, 1'b0, 1'b0, 64'h8000_0000_0000_0102, 1'b0, "acc_hold1");
        a_sample(1'b0, 0,  MODE_ACC, 1'b0, 1'b0, 64'h8000_0000_0000_0102, 1'b0, "acc_hold2");
        // This slot coincides with the clr-only cycle that follows.
        a_sample(1'b0, 0,  MODE_ACC, 1'b0, 1'b0, 64'h0,   1'b0, "clr_alone");
        a_sample(1'b0, 0,  MODE_ACC, 1'b1, 1'b0, 64'h0,   1'b0, "clr_hold");

        a_sample(1'b1, 3,  MODE_ACC, 1'b0, 1'b1, 64'h8,   1'b0, "acc_3");
        a_sample(1'b1, 4,  MODE_ACC, 1'b0, 1'b1, 64'h18,  1'b0, "acc_4");
        // Arrives together with the clr of the next step: clear, then OR.
        a_sample(1'b1, 3,  MODE_ACC, 1'b0, 1'b1, 64'h8,   1'b0, "clr_collide");
        a_sample(1'b1, 10, MODE_ONEHOT, 1'b1, 1'b1, 64'h400, 1'b0, "onehot_after_clr");
        a_sample(1'b0, 0,  MODE_ONEHOT, 1'b1, 1'b0, 64'h0, 1'b0, "clr_idle");

        // Reset lands on the edge where 7 advances and 9 would be captured.
        a_sample(1'b0, 0,  MODE_ONEHOT, 1'b0, 1'b0, 64'h0, 1'b0, "pre_reset_bubble");
        a_sample(1'b1, 7,  MODE_ONEHOT, 1'b0, 1'b0, 64'h0, 1'b0, "rst_kills_7");
        rst_step(1'b1, 9);
        a_sample(1'b0, 0,  MODE_ONEHOT, 1'b0, 1'b0, 64'h0, 1'b0, "post_reset_idle");
        a_sample(1'b1, 20, MODE_ONEHOT, 1'b0, 1'b1, 64'd1 << 20, 1'b0, "post_reset_sample");
        a_sample(1'b0, 0,  MODE_ONEHOT, 1'b0, 1'b0, 64'h0, 1'b0, "post_reset_tail1");
        a_sample(1'b0, 0,  MODE_ONEHOT, 1'b0, 1'b0, 64'h0, 1'b0, "post_reset_tail2");

        rst_step(1'b0, 0);
        rst_step(1'b0, 0);
        b_sample(1'b1, 255, "b_code255");
        b_sample(1'b1, 0,   "b_code0");
        b_sample(1'b1, 165, "b_code165");
        for (int i = 0; i < 4; i++) b_sample(1'b0, 0, "b_bubble");

        repeat (8) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover got %0d unchecked entries, first=%s due=%0d, want 0",
                     sb.size(), sb[0].name, sb[0].due);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
